// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared widths, entry layout and helpers for the instruction fetch queue
package inst_fetch_queue_pkg;

  localparam int ALL_CHECKPOINT_LEN = 8;
  localparam int EXCCODE_LEN        = 5;

  // One queue entry: a single instruction with its prediction and fetch-exception info.
  typedef struct packed {
    logic [31:0]                   inst;
    logic [31:0]                   pc;
    logic [31:0]                   dest;
    logic                          take;
    logic [ALL_CHECKPOINT_LEN-1:0] info;
    logic                          has_exc;
    logic                          is_refill;
    logic [EXCCODE_LEN-1:0]        exc_code;
  } ifq_entry_t;

  localparam int IFQ_ENTRY_LEN = $bits(ifq_entry_t);

  // Lane k of a fetch group sits k words after the group base PC.
  function automatic logic [31:0] lane_pc(input logic [31:0] base, input int k);
    return base + 32'(4 * k);
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// rtl/inst_fetch_queue_if.sv - IF/decode/repair signal bundle of the instruction fetch queue
interface inst_fetch_queue_if;
  import inst_fetch_queue_pkg::*;

  logic                            SBA_flush_w_i;
  logic                            IF_valid_i;
  logic [2:0]                      IF_instNum_i;
  logic [127:0]                    IF_inst_p_i;
  logic [31:0]                     IF_instBasePC_i;
  logic [3:0]                      IF_predTake_p_i;
  logic [127:0]                    IF_predDest_p_i;
  logic [4*ALL_CHECKPOINT_LEN-1:0] IF_predInfo_p_i;
  logic                            IF_hasException_i;
  logic                            IF_isRefill_i;
  logic [EXCCODE_LEN-1:0]          IF_ExcCode_i;
  logic                            IQ_ready_o;
  logic [1:0]                      ID_popNum_i;
  logic [1:0]                      IQ_valid_o;
  logic [63:0]                     IQ_inst_p_o;
  logic [63:0]                     IQ_PC_p_o;
  logic [63:0]                     IQ_predDest_p_o;
  logic [1:0]                      IQ_predTake_p_o;
  logic [2*ALL_CHECKPOINT_LEN-1:0] IQ_predInfo_p_o;
  logic [1:0]                      IQ_hasException_o;
  logic [1:0]                      IQ_isRefill_o;
  logic [2*EXCCODE_LEN-1:0]        IQ_ExcCode_p_o;

  modport master (
    output SBA_flush_w_i, IF_valid_i, IF_instNum_i, IF_inst_p_i, IF_instBasePC_i,
           IF_predTake_p_i, IF_predDest_p_i, IF_predInfo_p_i, IF_hasException_i,
           IF_isRefill_i, IF_ExcCode_i, ID_popNum_i,
    input  IQ_ready_o, IQ_valid_o, IQ_inst_p_o, IQ_PC_p_o, IQ_predDest_p_o,
           IQ_predTake_p_o, IQ_predInfo_p_o, IQ_hasException_o, IQ_isRefill_o, IQ_ExcCode_p_o
  );

  modport slave (
    input  SBA_flush_w_i, IF_valid_i, IF_instNum_i, IF_inst_p_i, IF_instBasePC_i,
           IF_predTake_p_i, IF_predDest_p_i, IF_predInfo_p_i, IF_hasException_i,
           IF_isRefill_i, IF_ExcCode_i, ID_popNum_i,
    output IQ_ready_o, IQ_valid_o, IQ_inst_p_o, IQ_PC_p_o, IQ_predDest_p_o,
           IQ_predTake_p_o, IQ_predInfo_p_o, IQ_hasException_o, IQ_isRefill_o, IQ_ExcCode_p_o
  );

endinterface

// File: rtl/inst_fetch_queue_lane_rotate.sv
// rtl/inst_fetch_queue_lane_rotate.sv - spreads the 4 fetch lanes onto circular-buffer entries starting at wp
module ifq_lane_rotate
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int PTR_LEN = $clog2(DEPTH)
) (
  input  logic                     push,
  input  logic [PTR_LEN-1:0]       wp,
  input  logic [2:0]               inst_num,
  input  ifq_entry_t [3:0]         lanes,
  output logic [DEPTH-1:0]         we,
  output ifq_entry_t [DEPTH-1:0]   wdata
);

  // Entry e receives lane (e - wp) mod DEPTH when that lane is part of the group;
  // the modular distance keeps program order across the DEPTH-1 -> 0 wrap.
  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    logic [PTR_LEN-1:0] ofs;
    assign ofs      = PTR_LEN'(e) - wp;
    assign we[e]    = push && (32'(ofs) < 32'(inst_num));
    assign wdata[e] = lanes[ofs[1:0]];
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - IF-to-decode instruction queue; IFQ_PERF_CNT_EN adds full/empty cycle counters
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_queue_if.slave  bus
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0]        IQ_fullCycles_o,
  output logic [31:0]        IQ_emptyCycles_o
`endif
);

  localparam int PTR_LEN = $clog2(DEPTH);

  logic [PTR_LEN-1:0]     rp, wp, rp_plus1;
  logic [PTR_LEN:0]       count;
  logic                   ready, push;
  logic [2:0]             push_num;
  logic [1:0]             pop_num;
  ifq_entry_t             mem [DEPTH];
  ifq_entry_t [3:0]       lanes;
  logic [DEPTH-1:0]       we;
  ifq_entry_t [DEPTH-1:0] wdata;
  ifq_entry_t             s0, s1;

  assign ready    = (count <= (PTR_LEN+1)'(DEPTH - 4));
  assign push     = bus.IF_valid_i && ready && !bus.SBA_flush_w_i;
  assign push_num = push ? bus.IF_instNum_i : 3'd0;
  assign rp_plus1 = rp + 1'b1;

  // Decode can never consume more than the queue holds.
  always_comb begin
    pop_num = bus.ID_popNum_i;
    if (count < (PTR_LEN+1)'(bus.ID_popNum_i)) pop_num = count[1:0];
  end

  // Unpack the flat IF buses into per-lane entries, replicating group exception info.
  always_comb begin
    lanes = '0;
    for (int k = 0; k < 4; k++) begin
      lanes[k].inst      = bus.IF_inst_p_i[32*k +: 32];
      lanes[k].pc        = lane_pc(bus.IF_instBasePC_i, k);
      lanes[k].dest      = bus.IF_predDest_p_i[32*k +: 32];
      lanes[k].take      = bus.IF_predTake_p_i[k];
      lanes[k].info      = bus.IF_predInfo_p_i[ALL_CHECKPOINT_LEN*k +: ALL_CHECKPOINT_LEN];
      lanes[k].has_exc   = bus.IF_hasException_i;
      lanes[k].is_refill = bus.IF_isRefill_i;
      lanes[k].exc_code  = bus.IF_ExcCode_i;
    end
  end

  ifq_lane_rotate #(.DEPTH(DEPTH), .PTR_LEN(PTR_LEN)) u_rotate (
    .push     (push),
    .wp       (wp),
    .inst_num (bus.IF_instNum_i),
    .lanes    (lanes),
    .we       (we),
    .wdata    (wdata)
  );

  // Pointer and occupancy update; a repair flush discards same-cycle push and pop.
  always_ff @(posedge clk) begin
    if (rst || bus.SBA_flush_w_i) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else begin
      rp    <= rp + PTR_LEN'(pop_num);
      wp    <= wp + PTR_LEN'(push_num);
      count <= count + (PTR_LEN+1)'(push_num) - (PTR_LEN+1)'(pop_num);
    end
  end

  // Entry storage; contents need no reset since only counted entries are ever shown.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we[i]) mem[i] <= wdata[i];
    end
  end

  // Present the two oldest entries; empty slots read as zero.
  always_comb begin
    s0 = (count >= (PTR_LEN+1)'(1)) ? mem[rp]       : '0;
    s1 = (count >= (PTR_LEN+1)'(2)) ? mem[rp_plus1] : '0;
    bus.IQ_ready_o        = ready;
    bus.IQ_valid_o        = {count >= (PTR_LEN+1)'(2), count >= (PTR_LEN+1)'(1)};
    bus.IQ_inst_p_o       = {s1.inst, s0.inst};
    bus.IQ_PC_p_o         = {s1.pc, s0.pc};
    bus.IQ_predDest_p_o   = {s1.dest, s0.dest};
    bus.IQ_predTake_p_o   = {s1.take, s0.take};
    bus.IQ_predInfo_p_o   = {s1.info, s0.info};
    bus.IQ_hasException_o = {s1.has_exc, s0.has_exc};
    bus.IQ_isRefill_o     = {s1.is_refill, s0.is_refill};
    bus.IQ_ExcCode_p_o    = {s1.exc_code, s0.exc_code};
  end

  // Flag IF writing into a full queue and decode over-popping (simulation only).
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.IF_valid_i && !ready))
        else $warning("IF group dropped while queue not ready");
      assert (32'(bus.ID_popNum_i) <= 32'(count))
        else $warning("decode pop exceeds queue occupancy");
    end
  end

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] full_cycles, empty_cycles;

  // Saturating occupancy statistics; only reset clears them, a flush does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_cycles  <= '0;
      empty_cycles <= '0;
    end else begin
      if (!ready && full_cycles != '1) full_cycles <= full_cycles + 32'd1;
      if (count == '0 && empty_cycles != '1) empty_cycles <= empty_cycles + 32'd1;
    end
  end

  assign IQ_fullCycles_o  = full_cycles;
  assign IQ_emptyCycles_o = empty_cycles;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int CK    = ALL_CHECKPOINT_LEN;
  localparam int EL    = EXCCODE_LEN;

  typedef struct packed {
    logic [31:0]   inst;
    logic [31:0]   pc;
    logic [31:0]   dest;
    logic          take;
    logic [CK-1:0] info;
    logic          exc;
    logic          refill;
    logic [EL-1:0] code;
  } rec_t;

  typedef struct {
    logic        flush;
    logic        valid;
    logic [2:0]  num;
    logic [31:0] base;
    logic [1:0]  pop;
    logic [1:0]  ev;
    logic        ey;
    logic [31:0] pc0;
    logic [31:0] pc1;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  inst_fetch_queue_if bus();

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] full_o, empty_o;
  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .IQ_fullCycles_o(full_o), .IQ_emptyCycles_o(empty_o)
  );
`else
  inst_fetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  rec_t        q[$];
  int unsigned m_full, m_empty;
  int          tests = 0;
  int          fails = 0;
  vec_t        tbl[$];

  task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour: occupancy statistics, then flush/reset, else pop oldest then append group.
  task automatic model_edge();
    int npop;
    rec_t r;
    if (q.size() > DEPTH - 4) m_full++;
    if (q.size() == 0) m_empty++;
    if (rst) begin
      q.delete();
      m_full = 0;
      m_empty = 0;
    end else if (bus.SBA_flush_w_i) begin
      q.delete();
    end else begin
      bit accept = bus.IF_valid_i && (q.size() <= DEPTH - 4);
      npop = int'(bus.ID_popNum_i);
      if (npop > q.size()) npop = q.size();
      repeat (npop) void'(q.pop_front());
      if (accept) begin
        for (int k = 0; k < int'(bus.IF_instNum_i); k++) begin
          r.inst   = bus.IF_inst_p_i[32*k +: 32];
          r.pc     = bus.IF_instBasePC_i + 32'(4 * k);
          r.dest   = bus.IF_predDest_p_i[32*k +: 32];
          r.take   = bus.IF_predTake_p_i[k];
          r.info   = bus.IF_predInfo_p_i[CK*k +: CK];
          r.exc    = bus.IF_hasException_i;
          r.refill = bus.IF_isRefill_i;
          r.code   = bus.IF_ExcCode_i;
          q.push_back(r);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    rec_t s0, s1;
    logic [1:0] ev;
    s0 = (q.size() > 0) ? q[0] : '0;
    s1 = (q.size() > 1) ? q[1] : '0;
    ev = (q.size() >= 2) ? 2'b11 : (q.size() == 1) ? 2'b01 : 2'b00;
    cmp({tag, "_valid"}, 256'(bus.IQ_valid_o), 256'(ev));
    cmp({tag, "_ready"}, 256'(bus.IQ_ready_o), 256'(q.size() <= DEPTH - 4));
    cmp({tag, "_data"},
        256'({bus.IQ_inst_p_o, bus.IQ_PC_p_o, bus.IQ_predDest_p_o, bus.IQ_predTake_p_o,
              bus.IQ_predInfo_p_o, bus.IQ_hasException_o, bus.IQ_isRefill_o, bus.IQ_ExcCode_p_o}),
        256'({s1.inst, s0.inst, s1.pc, s0.pc, s1.dest, s0.dest, s1.take, s0.take,
              s1.info, s0.info, s1.exc, s0.exc, s1.refill, s0.refill, s1.code, s0.code}));
`ifdef IFQ_PERF_CNT_EN
    cmp({tag, "_full_cnt"}, 256'(full_o), 256'(m_full));
    cmp({tag, "_empty_cnt"}, 256'(empty_o), 256'(m_empty));
`endif
  endtask

  task automatic drive(input logic flush, input logic valid, input logic [2:0] num,
                       input logic [31:0] base, input logic [1:0] pop,
                       input logic exc, input logic refill, input logic [EL-1:0] code);
    bus.SBA_flush_w_i     = flush;
    bus.IF_valid_i        = valid;
    bus.IF_instNum_i      = num;
    bus.IF_instBasePC_i   = base;
    bus.ID_popNum_i       = pop;
    bus.IF_hasException_i = exc;
    bus.IF_isRefill_i     = refill;
    bus.IF_ExcCode_i      = code;
    bus.IF_inst_p_i       = exc ? 128'd0 : {$urandom, $urandom, $urandom, $urandom};
    bus.IF_predDest_p_i   = {$urandom, $urandom, $urandom, $urandom};
    bus.IF_predTake_p_i   = 4'($urandom);
    bus.IF_predInfo_p_i   = (4*CK)'({$urandom, $urandom});
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 32'd0, 2'd0, 1'b0, 1'b0, '0);
  endtask

  function automatic vec_t mk(input logic flush, input logic valid, input logic [2:0] num,
                              input logic [31:0] base, input logic [1:0] pop, input logic [1:0] ev,
                              input logic ey, input logic [31:0] pc0, input logic [31:0] pc1);
    vec_t v;
    v.flush = flush; v.valid = valid; v.num = num; v.base = base; v.pop = pop;
    v.ev = ev; v.ey = ey; v.pc0 = pc0; v.pc1 = pc1;
    return v;
  endfunction

  initial begin
    // flush valid num base pop | valid ready pc0 pc1
    tbl.push_back(mk(0, 1, 3, 32'hBFC00008, 0, 2'b11, 1, 32'hBFC00008, 32'hBFC0000C));
    tbl.push_back(mk(0, 0, 0, 32'h0,        2, 2'b01, 1, 32'hBFC00010, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 2'b00, 1, 32'h0,        32'h0));
    tbl.push_back(mk(0, 1, 4, 32'h1000,     0, 2'b11, 1, 32'h1000,     32'h1004));
    tbl.push_back(mk(0, 1, 4, 32'h1010,     0, 2'b11, 1, 32'h1000,     32'h1004));
    tbl.push_back(mk(0, 1, 4, 32'h1020,     0, 2'b11, 1, 32'h1000,     32'h1004));
    tbl.push_back(mk(0, 1, 4, 32'h1030,     0, 2'b11, 0, 32'h1000,     32'h1004));
    tbl.push_back(mk(0, 1, 4, 32'h2000,     0, 2'b11, 0, 32'h1000,     32'h1004));
    tbl.push_back(mk(0, 0, 0, 32'h0,        2, 2'b11, 0, 32'h1008,     32'h100C));
    tbl.push_back(mk(0, 0, 0, 32'h0,        2, 2'b11, 1, 32'h1010,     32'h1014));
    tbl.push_back(mk(0, 1, 4, 32'h1040,     2, 2'b11, 0, 32'h1018,     32'h101C));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 2'b00, 1, 32'h0,        32'h0));
    tbl.push_back(mk(0, 1, 4, 32'h4000,     0, 2'b11, 1, 32'h4000,     32'h4004));
    tbl.push_back(mk(0, 1, 4, 32'h4010,     0, 2'b11, 1, 32'h4000,     32'h4004));
    tbl.push_back(mk(0, 1, 1, 32'h4020,     0, 2'b11, 1, 32'h4000,     32'h4004));
    tbl.push_back(mk(1, 1, 4, 32'h5000,     2, 2'b00, 1, 32'h0,        32'h0));
    tbl.push_back(mk(0, 1, 1, 32'h3000,     0, 2'b01, 1, 32'h3000,     32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 2'b00, 1, 32'h0,        32'h0));

    // Reset with junk requests pending.
    rst = 1'b1;
    drive(1'b0, 1'b1, 3'd4, 32'hDEAD0000, 2'd2, 1'b1, 1'b1, 5'h1F);
    step();
    step();
    rst = 1'b0;
    idle();
    check_model("reset");
    cmp("reset_valid", 256'(bus.IQ_valid_o), 256'(2'b00));
    cmp("reset_ready", 256'(bus.IQ_ready_o), 256'(1'b1));
    cmp("reset_data_zero",
        256'({bus.IQ_inst_p_o, bus.IQ_PC_p_o, bus.IQ_predDest_p_o, bus.IQ_predTake_p_o,
              bus.IQ_predInfo_p_o, bus.IQ_hasException_o, bus.IQ_isRefill_o, bus.IQ_ExcCode_p_o}),
        256'd0);

    // Directed table: ordering, full boundary, drop, push+pop, flush priority.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].flush, tbl[i].valid, tbl[i].num, tbl[i].base, tbl[i].pop, 1'b0, 1'b0, '0);
      step();
      idle();
      cmp($sformatf("vec%0d_valid", i), 256'(bus.IQ_valid_o), 256'(tbl[i].ev));
      cmp($sformatf("vec%0d_ready", i), 256'(bus.IQ_ready_o), 256'(tbl[i].ey));
      cmp($sformatf("vec%0d_pc", i), 256'(bus.IQ_PC_p_o), 256'({tbl[i].pc1, tbl[i].pc0}));
      check_model($sformatf("vec%0d", i));
    end

    // Wrap: walk the write pointer to entry 14 (currently 1), drain, then push an excepting group.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 3'd4, 32'h100 * i, 2'd0, 1'b0, 1'b0, '0);
      step();
    end
    drive(1'b0, 1'b1, 3'd1, 32'h900, 2'd0, 1'b0, 1'b0, '0);
    step();
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      idle();
      bus.ID_popNum_i = (q.size() >= 2) ? 2'd2 : 2'd1;
      step();
    end
    check_model("wrap_drained");
    drive(1'b0, 1'b1, 3'd4, 32'h80001000, 2'd0, 1'b1, 1'b0, 5'h04);
    step();
    idle();
    check_model("wrap_a");
    cmp("wrap_a_pc", 256'(bus.IQ_PC_p_o), 256'({32'h80001004, 32'h80001000}));
    cmp("wrap_a_exc", 256'({bus.IQ_hasException_o, bus.IQ_ExcCode_p_o}), 256'({2'b11, 5'h04, 5'h04}));
    bus.ID_popNum_i = 2'd2;
    step();
    idle();
    check_model("wrap_b");
    cmp("wrap_b_pc", 256'(bus.IQ_PC_p_o), 256'({32'h8000100C, 32'h80001008}));
    cmp("wrap_b_exc", 256'({bus.IQ_hasException_o, bus.IQ_ExcCode_p_o}), 256'({2'b11, 5'h04, 5'h04}));
    bus.ID_popNum_i = 2'd2;
    step();
    idle();
    cmp("wrap_empty", 256'(bus.IQ_valid_o), 256'(2'b00));

    // Randomized traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      int maxpop;
      logic exc;
      maxpop = (q.size() >= 2) ? 2 : q.size();
      exc = ($urandom_range(0, 7) == 0);
      drive(($urandom_range(0, 49) == 0),
            (q.size() <= DEPTH - 4) && ($urandom_range(0, 2) != 0),
            3'($urandom_range(1, 4)),
            {$urandom} & 32'hFFFF_FFFC,
            2'($urandom_range(0, maxpop)),
            exc, exc & 1'($urandom), 5'($urandom));
      step();
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch queue between the IF branch-select/check stage and decode. Each cycle it accepts one compressed group of 1–4 instructions from IF, together with their branch prediction data and fetch-exception info. It stores them in a circular buffer and presents the two oldest instructions to decode, which pops 0–2 per cycle. A back-end branch repair (SBA flush) empties it.

## Interface
- DEPTH, 16, number of entries; power of 2, ≥8
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- SBA_flush_w_i  in  1  back-end branch repair; discard all contents
- IF_valid_i  in  1  group write request
- IF_instNum_i  in  3  instructions in group, 1–4
- IF_inst_p_i  in  128  compressed instructions, lane 0 oldest
- IF_instBasePC_i  in  32  PC of lane 0
- IF_predTake_p_i  in  4  predicted take per lane
- IF_predDest_p_i  in  128  predicted destination per lane
- IF_predInfo_p_i  in  4*`ALL_CHECKPOINT_LEN  checkpoint per lane
- IF_hasException_i / IF_isRefill_i  in  1 / 1  group fetch exception, TLB refill flag
- IF_ExcCode_i  in  `EXCCODE  group exception code
- IQ_ready_o  out  1  queue can accept a 4-wide group
- ID_popNum_i  in  2  instructions consumed by decode, 0–2
- IQ_valid_o  out  2  slot valid (thermometer: 00/01/11)
- IQ_inst_p_o / IQ_PC_p_o / IQ_predDest_p_o  out  64 each  slot 0 in [31:0]
- IQ_predTake_p_o  out  2
- IQ_predInfo_p_o  out  2*`ALL_CHECKPOINT_LEN
- IQ_hasException_o / IQ_isRefill_o  out  2 / 2
- IQ_ExcCode_p_o  out  2*`EXCCODE_LEN

## Operation
- State: read pointer rp, write pointer wp (log2 DEPTH bits, natural wrap), count (log2 DEPTH + 1 bits).
- Push = IF_valid_i && IQ_ready_o && !SBA_flush_w_i. Lane k (k < IF_instNum_i) is written to entry wp+k, with PC = IF_instBasePC_i + 4k. Exception fields are replicated to every lane of the group. wp advances by IF_instNum_i.
- IF_valid_i while IQ_ready_o=0: the group is dropped. Raise a simulation assertion.
- Pop = min(ID_popNum_i, count). rp advances by Pop. Pop > count raises a simulation assertion.
- count_next = count + pushNum − Pop, with push and pop in the same cycle.
- IQ_ready_o = (count ≤ DEPTH−4). It is a function of registered count only.
- IQ_valid_o[0] = count≥1; IQ_valid_o[1] = count≥2. Slot j shows entry rp+j. Invalid slots drive zero.
- Flush has priority over push and pop. rp=wp=count=0 at the next edge; same-cycle push and pop are ignored.
- Exception entries carry whatever instruction data IF supplied (zero). The queue does not modify it.

## Timing
- Reset: rp=wp=count=0. IQ_valid_o=00, IQ_ready_o=1. All data outputs are 0.
- Write-to-read latency is 1 cycle: a group pushed at edge t is visible on the slots after edge t. There is no same-cycle bypass.
- Outputs are combinational from registered state only. There is no combinational path from IF_* or ID_popNum_i to any output.
- Flush asserted in cycle t: IQ_valid_o=00 and IQ_ready_o=1 from t+1.
- Full boundary: count=DEPTH−4 gives ready=1; count>DEPTH−4 gives ready=0.
- Wrap: a push straddling entry DEPTH−1→0 keeps program order across the wrap.

## Configuration
- IFQ_PERF_CNT_EN defined: adds outputs IQ_fullCycles_o[31:0] (cycles with IQ_ready_o=0) and IQ_emptyCycles_o[31:0] (cycles with count=0).
  - Both saturate at 0xFFFFFFFF.
  - Both are cleared by rst only, not by flush.
- IFQ_PERF_CNT_EN not defined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Add to MyDefines.v:
  - `IFQ_ENTRY_LEN (inst + PC + dest + take + checkpoint + exception fields)
  - field-offset macros for the entry layout
  - `IFQ_PTR_LEN
- Sub-module ifq_lane_rotate: expands the 4 input lanes into per-entry write enables and data, indexed by wp and IF_instNum_i. It is combinational and instantiated once.

## Test plan
- Reset: hold rst 2 cycles → IQ_valid_o=00, IQ_ready_o=1, all data outputs 0.
- Push 3 instructions, base PC 0xBFC00008 → next cycle IQ_valid_o=11 with PCs 0xBFC00008 / 0xBFC0000C. Pop 2 → IQ_valid_o=01, slot-0 PC 0xBFC00010.
- DEPTH=16, four 4-wide pushes, no pops:
  - after the third push: count=12, ready=1
  - after the fourth: ready=0
  - a fifth IF_valid_i is dropped and count stays 16
- count=12, push 4 and pop 2 in the same cycle → count=14, ready=0. Contents stay in order.
- Fill to count=9, then flush with push and pop in the same cycle → next cycle IQ_valid_o=00, ready=1. The first post-flush push appears in slot 0.
- wp=14, push 4 with base PC 0x80001000 (group has hasException=1, ExcCode=0x04) → entries 14, 15, 0, 1 read back in order with PCs +0/+4/+8/+C, exception flag 1 and code 0x04 on each.
